mul8_share_arb: RTL and testbench
=================================

# mul8_share_arb

Round-robin arbiter and two-stage scheduler that shares one combinational 8x8 approximate multiplier from the mul8 library among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the winning pair, drives it onto the external multiplier, registers the 16-bit product and returns it tagged with the requester index. It sits between the accelerator's lane front-ends and a single multiplier instance; the instance is connected at the parent level, so any library variant plugs in unchanged.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of the requester tag, equal to clog2(`NREQ`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input `NREQ`: per-requester operand valid.
- `req_a` input 8*`NREQ`: operand A; requester i occupies bits [8i+7:8i].
- `req_b` input 8*`NREQ`: operand B, packed the same way.
- `req_ready` output `NREQ`: per-requester accept (grant); at most one bit high.
- `mul_a` output 8: operand A to the external multiplier (stage-1 register).
- `mul_b` output 8: operand B to the external multiplier (stage-1 register).
- `mul_o` input 16: product returned by the external multiplier (combinational).
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_data` output 16: registered product.
- `rsp_id` output `IDW`: index of the requester that issued the operation.
- `ops_cnt` output 16: count of completed responses; wraps from 0xFFFF to 0.

## Operation
- **Stage 1 (S1):** holds `s1_valid`, `mul_a`, `mul_b` and `s1_id`. **Stage 2 (S2):** holds `rsp_valid`, `rsp_data` and `rsp_id`.
- **Stage advance rules:**
  - `s2_adv` = !`rsp_valid` | `rsp_ready`.
  - `s1_adv` = !`s1_valid` | `s2_adv`.
- **Arbitration:**
  - A grant happens only when `s1_adv`=1 and at least one `req_valid` bit is set.
  - The winner is the first set `req_valid` bit searching upward from `rr_ptr`, wrapping modulo `NREQ`.
  - `req_ready[i]` = `s1_adv` & winner==i. It may depend combinationally on `req_valid`.
  - A transfer occurs when `req_valid[i]` & `req_ready[i]`.
- **On a transfer from requester i:**
  - S1 loads `req_a[i]`, `req_b[i]` and id i; `s1_valid` is set.
  - `rr_ptr` becomes (i+1) mod `NREQ`.
- **With no grant:** `rr_ptr` holds. If `s1_adv`=1, `s1_valid` clears. The S1 data registers hold their last value.
- **S2 update:** when `s2_adv`=1, S2 loads `mul_o`, `s1_id` and `s1_valid`. Otherwise S2 holds, and `rsp_data`/`rsp_id` stay stable while `rsp_valid`=1.
- **Counter:** `ops_cnt` increments on each cycle with `rsp_valid` & `rsp_ready`.
- **`rr_ptr` range:** `rr_ptr` only ever takes values 0..`NREQ`-1. A non-power-of-two `NREQ` wraps at `NREQ`, not at 2^`IDW`.
- **Reset:** while `rst_n`=0, asynchronously:
  - `s1_valid`=0, `rsp_valid`=0, `rr_ptr`=0, `ops_cnt`=0.
  - `mul_a`=0, `mul_b`=0, `rsp_data`=0, `rsp_id`=0.
  - `req_ready` is forced to all zeros.
  - Operations in flight are dropped without a response.

## Timing
- **Latency:** a transfer in cycle N gives `rsp_valid`=1 in cycle N+2 if `rsp_ready` stays high.
- **Throughput:** one operation per cycle when `rsp_ready` is held high.
- **Multiplier path:** `mul_o` must settle within one cycle of the S1 registers. No multicycle path is allowed.
- **Backpressure:** with `rsp_ready`=0, the pipeline fills (S1 and S2 both valid), after which `req_ready` is all zeros. When `rsp_ready` rises, `req_ready` may assert in the same cycle.
- **Ordering:** responses leave in grant order. No operation is lost or duplicated.
- **Fairness:** with all requesters continuously valid, each requester is granted exactly once in every `NREQ` consecutive grants.
- **Reset release:** the first grant is possible in the first clock edge after `rst_n` deasserts; priority starts at requester 0.

## Test plan
- **Single operation.** Bench models `mul_o` = `mul_a`*`mul_b`. Stimulus: requester 2 only, `req_a`=0x0F, `req_b`=0x11. Required: `req_ready`=4'b0100 in cycle 0; in cycle 2, `rsp_valid`=1, `rsp_data`=0x00FF, `rsp_id`=2; afterwards `ops_cnt`=1.
- **Round-robin fairness.** Stimulus: all 4 requesters continuously valid, requester i with A=i+1, B=3, `rsp_ready`=1. Required: grant order 0,1,2,3,0,…; response sequence 3,6,9,12 repeating; one response per cycle.
- **Backpressure.**
  - Stimulus: hold `rsp_ready`=0 with requesters 0 and 1 valid.
  - Required: exactly two grants (0 then 1), then `req_ready`=0; `rsp_data` stays stable.
  - Stimulus: release `rsp_ready`.
  - Required: responses with ids 0 then 1 arrive in consecutive cycles, and a grant to requester 0 occurs in the release cycle.
- **Pointer hold.** Stimulus: grant requester 3 (`rr_ptr` becomes 0), idle 5 cycles, then requesters 1 and 3 valid together. Required: requester 1 wins first.
- **Counter wrap.** Stimulus: 65537 completed responses. Required: `ops_cnt` reads 0xFFFF after 65535 completions, 0x0000 after 65536, and 0x0001 after 65537.
- **Reset mid-operation.** Stimulus: assert `rst_n`=0 asynchronously between edges while S1 and S2 are both valid. Required: `rsp_valid` and `req_ready` go to 0 immediately; after release there is no stale response, and the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/mul8_share_arb.sv
// Round-robin share of one external 8x8 multiplier among NREQ valid/ready requesters.
// Latency: grant in cycle N -> rsp_valid in cycle N+2; one op per cycle at full rate.
// Backpressure: rsp_ready low stalls S2, then S1, then drops all req_ready grants.
module mul8_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       mul_o,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       ops_cnt
);

    logic           s1_valid;
    logic [IDW-1:0] s1_id;
    logic [IDW-1:0] rr_ptr;
    logic           s2_adv;
    logic           s1_adv;
    logic           grant;
    logic [IDW-1:0] win;
    logic [IDW-1:0] rr_nxt;
    logic [IDW:0]   sum;
    logic [7:0]     a_sel;
    logic [7:0]     b_sel;

    assign s2_adv = !rsp_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // Scan offsets from highest to lowest so the smallest offset from rr_ptr wins.
    // The modulo is done explicitly so non-power-of-two NREQ never aliases.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            if (req_valid[sum[IDW-1:0]]) begin
                grant = 1'b1;
                win   = sum[IDW-1:0];
            end
        end
    end

    assign rr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

    // Gated by rst_n so no requester sees a grant while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && s1_adv && grant) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel = req_a[8*i +: 8];
                b_sel = req_b[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ops_cnt   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= grant;
                if (grant) begin
                    mul_a  <= a_sel;
                    mul_b  <= b_sel;
                    s1_id  <= win;
                    rr_ptr <= rr_nxt;
                end
            end
            if (s2_adv) begin
                rsp_valid <= s1_valid;
                rsp_data  <= mul_o;
                rsp_id    <= s1_id;
            end
            if (rsp_valid && rsp_ready) begin
                ops_cnt <= ops_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mul8_share_arb.sv
// Directed bench for mul8_share_arb: inputs change on the falling edge, outputs are
// sampled 1ns later, so every rising edge sees stable stimulus.
module tb_mul8_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_o;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] ops_cnt;

    int checks = 0;
    int errors = 0;

    mul8_share_arb #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_o     (mul_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .ops_cnt   (ops_cnt)
    );

    // Exact multiplier standing in for the library instance.
    assign mul_o = 16'(mul_a) * 16'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (ops_cnt !== 16'h0) begin errors++; $display("FAIL rst_ops_cnt got %h exp 0000", ops_cnt); end
        checks++; if (mul_a !== 8'h0 || mul_b !== 8'h0) begin errors++; $display("FAIL rst_mul_ab got %h/%h exp 00/00", mul_a, mul_b); end
        checks++; if (rsp_data !== 16'h0 || rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp got %h/%0d exp 0000/0", rsp_data, rsp_id); end
        @(negedge clk);
        req_valid = 4'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_a = 32'h000F_0000;
        req_b = 32'h0011_0000;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %b exp 0", rsp_valid); end
        checks++; if (mul_a !== 8'h0F || mul_b !== 8'h11) begin errors++; $display("FAIL single_s1 got %h/%h exp 0f/11", mul_a, mul_b); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_data !== 16'h00FF) begin errors++; $display("FAIL single_rsp_data got %h exp 00ff", rsp_data); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got %0d exp 2", rsp_id); end
        @(negedge clk);
        #1;
        checks++; if (ops_cnt !== 16'd1) begin errors++; $display("FAIL single_ops_cnt got %0d exp 1", ops_cnt); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_dup_rsp got %b exp 0", rsp_valid); end
        @(negedge clk);
    endtask

    // rr_ptr is 3 on entry (last grant was requester 2).
    task automatic test_ptr_hold();
        req_a = 32'h0302_0102;
        req_b = 32'h0202_0202;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL hold_grant3 got %b exp 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (5) @(negedge clk);
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_first got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL hold_second got %b exp 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ops_cnt !== 16'd4) begin errors++; $display("FAIL hold_ops_cnt got %0d exp 4", ops_cnt); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        req_a = 32'h0403_0201;
        req_b = 32'h0303_0303;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
            if (k >= 2) begin
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid k=%0d got %b exp 1", k, rsp_valid); end
                checks++; if (rsp_data !== 16'(3 * ((k - 2) % 4 + 1))) begin errors++; $display("FAIL rr_rsp_data k=%0d got %0d exp %0d", k, rsp_data, 3 * ((k - 2) % 4 + 1)); end
                checks++; if (rsp_id !== 2'((k - 2) % 4)) begin errors++; $display("FAIL rr_rsp_id k=%0d got %0d exp %0d", k, rsp_id, (k - 2) % 4); end
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ops_cnt !== 16'd16) begin errors++; $display("FAIL rr_ops_cnt got %0d exp 16", ops_cnt); end
        @(negedge clk);
    endtask

    // rr_ptr is 0 on entry; requester 0 computes 7*2, requester 1 computes 5*2.
    task automatic test_backpressure();
        req_a = 32'h0000_0507;
        req_b = 32'h0000_0202;
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b exp 0001", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got %b exp 0010", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL bp_head got %b/%0d exp 1/0", rsp_valid, rsp_id); end
        checks++; if (rsp_data !== 16'd14) begin errors++; $display("FAIL bp_data got %0d exp 14", rsp_data); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_still_full got %b exp 0000", req_ready); end
        checks++; if (rsp_data !== 16'd14 || rsp_id !== 2'd0) begin errors++; $display("FAIL bp_stable got %0d/%0d exp 14/0", rsp_data, rsp_id); end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_grant got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'd10) begin errors++; $display("FAIL bp_second got %b/%0d/%0d exp 1/1/10", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd14) begin errors++; $display("FAIL bp_third got %b/%0d/%0d exp 1/0/14", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", rsp_valid); end
        checks++; if (ops_cnt !== 16'd19) begin errors++; $display("FAIL bp_ops_cnt got %0d exp 19", ops_cnt); end
        @(negedge clk);
    endtask

    // rr_ptr is 1 on entry.
    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_full got %b/%b exp 1/0000", rsp_valid, req_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_req_ready got %b exp 0000", req_ready); end
        checks++; if (ops_cnt !== 16'd0) begin errors++; $display("FAIL mid_ops_cnt got %0d exp 0", ops_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0110;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b exp 0", rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL mid_new_rsp got %b/%0d exp 1/1", rsp_valid, rsp_id); end
        repeat (2) @(negedge clk);
    endtask

    // After a clean reset, requester 0 streams; grant in cycle n completes at the end of cycle n+2.
    task automatic test_counter_wrap();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int n = 0; n <= 65539; n++) begin
            req_valid = (n <= 65536) ? 4'b0001 : 4'b0000;
            #1;
            if (n == 2) begin
                checks++; if (ops_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_start got %h exp 0000", ops_cnt); end
            end
            if (n == 65537) begin
                checks++; if (ops_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h exp ffff", ops_cnt); end
            end
            if (n == 65538) begin
                checks++; if (ops_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", ops_cnt); end
            end
            if (n == 65539) begin
                checks++; if (ops_cnt !== 16'h0001) begin errors++; $display("FAIL wrap_one got %h exp 0001", ops_cnt); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_ptr_hold();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
